sram_ctrl: RTL
==============

// Module: sram_ctrl
// PURPOSE
//  Initiator side of the asynchronous 16-bit external SRAM interface. Accepts single-word
//  read/write requests from on-chip logic, drives RAMCS/RAMWE/RAMOE/RAMUB/RAMLB/ADR and
//  the bidirectional DAT bus with programmable wait states, and returns read data.
//  Sits in chip between user logic (e.g. button-driven test pattern) and the SRAM pins.
// PARAMETERS
//  ADDR_W   18  SRAM word address width
//  DATA_W   16  SRAM data width (two byte lanes; fixed at 16)
//  RD_WAIT  2   cycles CS/OE held asserted before read sample (>=1)
//  WR_WAIT  2   cycles RAMWE held low per write (>=1)
// PORTS
//  clk        in   1       system clock
//  greset     in   1       asynchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller idle; request accepted when valid&ready at posedge
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  req_be     in   2       byte enables, [1]=upper, [0]=lower
//  resp_valid out  1       one-cycle pulse: resp_rdata valid (reads only)
//  resp_rdata out  DATA_W  read data, disabled lanes forced to 8'h00
//  RAMCS,RAMWE,RAMOE,RAMUB,RAMLB out 1  SRAM controls, active low
//  ADR        out  ADDR_W  SRAM address
//  DAT        inout DATA_W SRAM data bus
// BEHAVIOUR
//  - One clock (clk); reset greset is asynchronous, active-high.
//  - Reset (async, also mid-operation): all RAM* controls=1, ADR=0, DAT=Z, resp_valid=0,
//    resp_rdata=0, state=IDLE; any in-flight access is dropped, no response issued.
//  - All SRAM pins and DAT output enable are registered (no combinational glitches on WE).
//  - req_ready = (state==IDLE), combinational from state; request fields latched on accept.
//  - States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN.
//  - Read: accept edge E0 -> RD for RD_WAIT cycles: CS=0, OE=0, WE=1, UB/LB=~be, ADR=addr,
//    DAT=Z. At edge E0+RD_WAIT: DAT captured (lanes masked by be), resp_valid=1 for one
//    cycle, CS/OE/UB/LB return to 1, state->IDLE.
//  - Write: WR_SETUP 1 cycle (CS=0, WE=1, OE=1, ADR, DAT driven) -> WR_PULSE WR_WAIT cycles
//    (WE=0, UB/LB=~be) -> WR_HOLD 1 cycle (WE=1, UB/LB=1, CS=0, DAT still driven) -> IDLE
//    with DAT=Z. req_ready low for WR_WAIT+2 cycles after accept; no resp_valid.
//  - Turnaround: a write accepted on the cycle immediately after a read completes passes
//    through TURN (1 cycle, all controls 1, DAT=Z) before WR_SETUP. Read->read,
//    write->read, write->write need no gap.
//  - DAT is never driven while RAMOE=0; OE and DAT-drive are mutually exclusive each cycle.
//  - be=2'b00: access runs with normal timing, both lanes stay deasserted; read returns 0.
//  - Wait counter width = $clog2(max(RD_WAIT,WR_WAIT))+1; counts down, no wrap.
// STRUCTURE
//  - Shared package sram_pkg: state encoding, default RD_WAIT/WR_WAIT, lane index constants.
//  - One sub-module sram_dat_io: DAT tri-state buffer (oe, out, in); rest flat in sram_ctrl.
// TESTING  (bench SRAM model returns ADR[15:0] on enabled lanes during reads)
//  1. greset=1 mid-run -> RAMCS/WE/OE/UB/LB=1, DAT=Z, resp_valid=0; after release req_ready=1.
//  2. read 18'h00123 be=11 -> CS=OE=0 exactly 2 cycles, ADR=18'h00123, resp_valid 1 cycle,
//     resp_rdata=16'h0123.
//  3. read 18'h3ABCD be=01 -> RAMLB=0, RAMUB=1, resp_rdata=16'h00CD.
//  4. write 18'h00010 data 16'hBEEF be=10 -> WE high setup 1 cycle, WE=0 2 cycles with
//     RAMUB=0/RAMLB=1, DAT=BEEF setup..hold, then Z; req_ready low 4 cycles.
//  5. read 0x00001 then write 0x00002 back-to-back -> one TURN cycle, DAT=Z, CS=1 between
//     OE deassert and first DAT drive; no cycle with OE=0 and DAT driven.
//  6. greset pulsed during WR_PULSE -> WE/CS go high without clock edge, DAT=Z; next read
//     of 18'h00055 completes normally with resp_rdata=16'h0055.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding, wait defaults and byte-lane indices for the SRAM initiator
package sram_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_TURN     = 3'd5
    } state_t;

    localparam int RD_WAIT_DEF = 2;
    localparam int WR_WAIT_DEF = 2;

    // byte-enable / data-lane positions
    localparam int LANE_LO = 0;
    localparam int LANE_HI = 1;

endpackage

// File: rtl/sram_dat_io.sv
// rtl/sram_dat_io.sv - tri-state buffer for the bidirectional SRAM data bus
module sram_dat_io #(
    parameter int DATA_W = 16
) (
    input  logic              i_oe,
    input  logic [DATA_W-1:0] i_out,
    output logic [DATA_W-1:0] o_in,
    inout  wire  [DATA_W-1:0] io_dat
);

    assign io_dat = i_oe ? i_out : {DATA_W{1'bz}};
    assign o_in   = io_dat;

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-word async SRAM initiator with programmable read/write wait states
import sram_pkg::*;

module sram_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF
) (
    input  logic              clk,
    input  logic              greset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              RAMCS,
    output logic              RAMWE,
    output logic              RAMOE,
    output logic              RAMUB,
    output logic              RAMLB,
    output logic [ADDR_W-1:0] ADR,
    inout  wire  [DATA_W-1:0] DAT
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]         r_be, w_be_nxt;
    logic               r_last_rd, w_last_rd_nxt;
    logic [DATA_W-1:0]  r_dout;
    logic               r_dat_oe, w_dat_oe;
    logic               w_cs_n, w_we_n, w_oe_n, w_ub_n, w_lb_n;
    logic               w_accept, w_cap;
    logic [DATA_W-1:0]  w_din;

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = req_valid && (r_state == S_IDLE);

    // next-state sequencing, then pin levels decoded from the state being entered so pins can be registered
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_be_nxt      = r_be;
        w_last_rd_nxt = r_last_rd;
        w_cap         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_last_rd_nxt = 1'b0;
                if (req_valid) begin
                    w_be_nxt = req_be;
                    if (req_we) begin
                        // the SRAM may still be releasing DAT after OE rose; give it a dead cycle
                        w_state_nxt = r_last_rd ? S_TURN : S_WR_SETUP;
                    end else begin
                        w_state_nxt = S_RD;
                        w_cnt_nxt   = CNT_W'(RD_WAIT - 1);
                    end
                end
            end
            S_RD: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = S_IDLE;
                    w_cap         = 1'b1;
                    w_last_rd_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_TURN:     w_state_nxt = S_WR_SETUP;
            S_WR_SETUP: begin
                w_state_nxt = S_WR_PULSE;
                w_cnt_nxt   = CNT_W'(WR_WAIT - 1);
            end
            S_WR_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WR_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_WR_HOLD:  w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase

        w_cs_n   = 1'b1;
        w_we_n   = 1'b1;
        w_oe_n   = 1'b1;
        w_ub_n   = 1'b1;
        w_lb_n   = 1'b1;
        w_dat_oe = 1'b0;
        case (w_state_nxt)
            S_RD: begin
                w_cs_n = 1'b0;
                w_oe_n = 1'b0;
                w_ub_n = ~w_be_nxt[LANE_HI];
                w_lb_n = ~w_be_nxt[LANE_LO];
            end
            S_WR_SETUP: begin
                w_cs_n   = 1'b0;
                w_dat_oe = 1'b1;
            end
            S_WR_PULSE: begin
                w_cs_n   = 1'b0;
                w_we_n   = 1'b0;
                w_ub_n   = ~w_be_nxt[LANE_HI];
                w_lb_n   = ~w_be_nxt[LANE_LO];
                w_dat_oe = 1'b1;
            end
            S_WR_HOLD: begin
                w_cs_n   = 1'b0;
                w_dat_oe = 1'b1;
            end
            default: ;
        endcase
    end

    // state register plus request fields latched on accept
    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_be      <= 2'b00;
            r_last_rd <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_be      <= w_be_nxt;
            r_last_rd <= w_last_rd_nxt;
            if (w_accept) begin
                r_dout <= req_wdata;
            end
        end
    end

    // registered SRAM pins, DAT drive enable and read response
    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            RAMCS      <= 1'b1;
            RAMWE      <= 1'b1;
            RAMOE      <= 1'b1;
            RAMUB      <= 1'b1;
            RAMLB      <= 1'b1;
            ADR        <= '0;
            r_dat_oe   <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            RAMCS      <= w_cs_n;
            RAMWE      <= w_we_n;
            RAMOE      <= w_oe_n;
            RAMUB      <= w_ub_n;
            RAMLB      <= w_lb_n;
            r_dat_oe   <= w_dat_oe;
            resp_valid <= w_cap;
            if (w_accept) begin
                ADR <= req_addr;
            end
            if (w_cap) begin
                resp_rdata[LANE_HI*8 +: 8] <= r_be[LANE_HI] ? w_din[LANE_HI*8 +: 8] : 8'h00;
                resp_rdata[LANE_LO*8 +: 8] <= r_be[LANE_LO] ? w_din[LANE_LO*8 +: 8] : 8'h00;
            end
        end
    end

    sram_dat_io #(
        .DATA_W (DATA_W)
    ) u_dat_io (
        .i_oe   (r_dat_oe),
        .i_out  (r_dout),
        .o_in   (w_din),
        .io_dat (DAT)
    );

endmodule
